fifo_access_controller: RTL and testbench

//  Sequences the level-held push/pop handshake of the QuickRS232 fifo and shares it between one writer
//  (e.g. host/RX side) and one reader (e.g. UART TX engine). Converts simple req/ack requests into timed

---
 rtl/fifo_access_controller.sv | 193 +++++++++++++++++++
 tb/tb_fifo_access_controller.sv | 415 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_access_controller.sv
// fifo_access_controller: shares the QuickRS232 fifo push/pop strobes
// between one writer and one reader, tracks occupancy, checks fifo flags.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   wr_req/wr_data      writer request and word; wr_ack pulses on commit
//   wr_full             occupancy at FIFO_SIZE
//   rd_req              reader request; rd_valid pulses when rd_data updates
//   rd_empty            occupancy at zero
//   count               words stored
//   sync_err            sticky flag/count disagreement
//   fifo_*              strobes and data to/from the fifo
module fifo_access_controller #(
  parameter int FIFO_SIZE   = 8,
  parameter int DATA_WIDTH  = 8,
  parameter int HOLD_CYCLES = 2,
  parameter int GAP_CYCLES  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_req,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_ack,
  output logic                  wr_full,
  input  logic                  rd_req,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  rd_empty,
  output logic [15:0]           count,
  output logic                  sync_err,
  output logic                  fifo_clear,
  output logic                  fifo_push,
  output logic                  fifo_pop,
  output logic [DATA_WIDTH-1:0] fifo_in_data,
  input  logic [DATA_WIDTH-1:0] fifo_out_data,
  input  logic                  fifo_pushed_last,
  input  logic                  fifo_popped_last
);

  typedef enum logic [2:0] {
    S_RESET,
    S_INIT,
    S_IDLE,
    S_WR_HOLD,
    S_WR_GAP,
    S_RD_HOLD,
    S_RD_GAP
  } state_t;

  localparam int TW = 8;
  localparam logic [TW-1:0] HOLD_LAST = TW'(HOLD_CYCLES - 1);
  localparam logic [TW-1:0] GAP_LAST  = TW'(GAP_CYCLES - 1);
  localparam logic [15:0]   FULL_CNT  = 16'(FIFO_SIZE);

  state_t                state, state_d;
  logic [TW-1:0]         tmr, tmr_d;
  logic [15:0]           count_d;
  logic [DATA_WIDTH-1:0] rd_data_d, in_data_d;
  logic                  sync_err_d, clear_d;
  logic                  push_d, pop_d;
  logic                  wr_ack_d, rd_valid_d;
  // last_wr: last grant went to the writer (round-robin pointer)
  logic                  last_wr, last_wr_d;
  // settled: at least one full IDLE cycle has elapsed
  logic                  settled, settled_d;
  logic                  wr_elig, rd_elig;
  logic                  grant_wr, grant_rd;
  logic                  flag_bad;

  assign wr_full  = (count == FULL_CNT);
  assign rd_empty = (count == 16'd0);

  assign wr_elig  = wr_req & ~wr_full;
  assign rd_elig  = rd_req & ~rd_empty;
  assign grant_wr = wr_elig & (~rd_elig | ~last_wr);
  assign grant_rd = rd_elig & (~wr_elig | last_wr);

  assign flag_bad = (fifo_pushed_last != wr_full)
                  | (fifo_popped_last != rd_empty);

  always_comb begin
    state_d    = state;
    tmr_d      = tmr;
    count_d    = count;
    rd_data_d  = rd_data;
    sync_err_d = sync_err;
    clear_d    = 1'b0;
    push_d     = fifo_push;
    pop_d      = fifo_pop;
    in_data_d  = fifo_in_data;
    wr_ack_d   = 1'b0;
    rd_valid_d = 1'b0;
    last_wr_d  = last_wr;
    settled_d  = 1'b0;
    unique case (state)
      S_RESET: begin
        state_d = S_INIT;
        tmr_d   = GAP_LAST;
      end
      S_INIT: begin
        if (tmr == '0) state_d = S_IDLE;
        else           tmr_d   = tmr - TW'(1);
      end
      S_IDLE: begin
        settled_d = ~(grant_wr | grant_rd);
        if (settled && flag_bad) sync_err_d = 1'b1;
        if (grant_wr) begin
          in_data_d = wr_data;
          push_d    = 1'b1;
          last_wr_d = 1'b1;
          tmr_d     = HOLD_LAST;
          state_d   = S_WR_HOLD;
        end else if (grant_rd) begin
          pop_d     = 1'b1;
          last_wr_d = 1'b0;
          tmr_d     = HOLD_LAST;
          state_d   = S_RD_HOLD;
        end
      end
      S_WR_HOLD: begin
        if (tmr == '0) begin
          push_d  = 1'b0;
          tmr_d   = GAP_LAST;
          state_d = S_WR_GAP;
        end else begin
          tmr_d = tmr - TW'(1);
        end
      end
      S_WR_GAP: begin
        if (tmr == '0) begin
          if (count != FULL_CNT) count_d = count + 16'd1;
          wr_ack_d = 1'b1;
          state_d  = S_IDLE;
        end else begin
          tmr_d = tmr - TW'(1);
        end
      end
      S_RD_HOLD: begin
        if (tmr == '0) begin
          pop_d   = 1'b0;
          tmr_d   = GAP_LAST;
          state_d = S_RD_GAP;
        end else begin
          tmr_d = tmr - TW'(1);
        end
      end
      S_RD_GAP: begin
        if (tmr == '0) begin
          if (count != 16'd0) count_d = count - 16'd1;
          rd_data_d  = fifo_out_data;
          rd_valid_d = 1'b1;
          state_d    = S_IDLE;
        end else begin
          tmr_d = tmr - TW'(1);
        end
      end
      default: state_d = S_RESET;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_RESET;
      tmr          <= '0;
      count        <= '0;
      rd_data      <= '0;
      sync_err     <= 1'b0;
      fifo_clear   <= 1'b1;
      fifo_push    <= 1'b0;
      fifo_pop     <= 1'b0;
      fifo_in_data <= '0;
      wr_ack       <= 1'b0;
      rd_valid     <= 1'b0;
      last_wr      <= 1'b0;
      settled      <= 1'b0;
    end else begin
      state        <= state_d;
      tmr          <= tmr_d;
      count        <= count_d;
      rd_data      <= rd_data_d;
      sync_err     <= sync_err_d;
      fifo_clear   <= clear_d;
      fifo_push    <= push_d;
      fifo_pop     <= pop_d;
      fifo_in_data <= in_data_d;
      wr_ack       <= wr_ack_d;
      rd_valid     <= rd_valid_d;
      last_wr      <= last_wr_d;
      settled      <= settled_d;
    end
  end

endmodule

// File: tb/tb_fifo_access_controller.sv
// Directed bench for fifo_access_controller.
// Contains a small behavioural model of the QuickRS232 fifo.
module tb_fifo_access_controller;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_req = 1'b0;
  logic [7:0]  wr_data = 8'h00;
  logic        wr_ack;
  logic        wr_full;
  logic        rd_req = 1'b0;
  logic [7:0]  rd_data;
  logic        rd_valid;
  logic        rd_empty;
  logic [15:0] count;
  logic        sync_err;
  logic        fifo_clear;
  logic        fifo_push;
  logic        fifo_pop;
  logic [7:0]  fifo_in_data;
  logic [7:0]  fifo_out_data;
  logic        fifo_pushed_last;
  logic        fifo_popped_last;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fifo_access_controller #(
    .FIFO_SIZE(8), .DATA_WIDTH(8),
    .HOLD_CYCLES(2), .GAP_CYCLES(2)
  ) dut (
    .clk(clk), .rst(rst),
    .wr_req(wr_req), .wr_data(wr_data),
    .wr_ack(wr_ack), .wr_full(wr_full),
    .rd_req(rd_req), .rd_data(rd_data),
    .rd_valid(rd_valid), .rd_empty(rd_empty),
    .count(count), .sync_err(sync_err),
    .fifo_clear(fifo_clear),
    .fifo_push(fifo_push), .fifo_pop(fifo_pop),
    .fifo_in_data(fifo_in_data),
    .fifo_out_data(fifo_out_data),
    .fifo_pushed_last(fifo_pushed_last),
    .fifo_popped_last(fifo_popped_last)
  );

  // fifo model: acts on rising strobes, out_data holds last popped word
  logic [7:0] mq[$];
  logic [7:0] m_out = 8'h00;
  logic       m_full = 1'b0;
  logic       m_empty = 1'b1;
  logic       pp = 1'b0;
  logic       pq = 1'b0;
  logic       force_pl = 1'b0;
  int         sz;

  always @(posedge clk) begin
    if (fifo_clear) begin
      mq.delete();
      m_out <= 8'h00;
    end else begin
      if (fifo_push && !pp) mq.push_back(fifo_in_data);
      if (fifo_pop && !pq && mq.size() > 0) begin
        m_out <= mq[0];
        mq.pop_front();
      end
    end
    sz = mq.size();
    m_full  <= (sz == 8);
    m_empty <= (sz == 0);
    pp <= fifo_push;
    pq <= fifo_pop;
  end

  assign fifo_out_data    = m_out;
  assign fifo_pushed_last = m_full;
  assign fifo_popped_last = force_pl ? 1'b0 : m_empty;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // lat = cycles from grant edge to ack (-1 if none), pc = push cycles
  task automatic do_write(input logic [7:0] d,
                          output int lat, output int pc);
    lat = -1;
    pc = 0;
    wr_data = d;
    wr_req = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (fifo_push) pc++;
      if (wr_ack) begin
        lat = i;
        break;
      end
    end
    wr_req = 1'b0;
  endtask

  task automatic do_read(output int lat, output int pc,
                         output logic [7:0] d);
    lat = -1;
    pc = 0;
    d = 8'h00;
    rd_req = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (fifo_pop) pc++;
      if (rd_valid) begin
        lat = i;
        d = rd_data;
        break;
      end
    end
    rd_req = 1'b0;
  endtask

  task automatic test_reset;
    int lat, pc;
    logic [7:0] d;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (fifo_clear !== 1'b1) begin
        failures++;
        $display("FAIL rst_clear got=%b exp=1", fifo_clear);
      end
    end
    checks++;
    if (count !== 16'd0 || rd_empty !== 1'b1 || sync_err !== 1'b0) begin
      failures++;
      $display("FAIL rst_state got=%0d/%b/%b exp=0/1/0",
               count, rd_empty, sync_err);
    end
    checks++;
    if ({fifo_push, fifo_pop, wr_ack, rd_valid, wr_full} !== 5'b0) begin
      failures++;
      $display("FAIL rst_outs got=%b exp=00000",
               {fifo_push, fifo_pop, wr_ack, rd_valid, wr_full});
    end
    rst = 1'b0;
    tick();
    checks++;
    if (fifo_clear !== 1'b0) begin
      failures++;
      $display("FAIL clear_drop got=%b exp=0", fifo_clear);
    end
    // request held from first INIT cycle: IDLE at edge 3, grant 4, ack 8
    wr_data = 8'h5A;
    wr_req = 1'b1;
    lat = -1;
    for (int i = 2; i <= 14; i++) begin
      tick();
      if (wr_ack) begin
        lat = i;
        break;
      end
    end
    wr_req = 1'b0;
    checks++;
    if (lat != 8) begin
      failures++;
      $display("FAIL init_len got=%0d exp=8", lat);
    end
    do_read(lat, pc, d);
    checks++;
    if (d !== 8'h5A || count !== 16'd0) begin
      failures++;
      $display("FAIL init_rd got=%h/%0d exp=5a/0", d, count);
    end
  endtask

  task automatic test_write_read;
    int lat, pc;
    logic [7:0] d;
    do_write(8'hA5, lat, pc);
    checks++;
    if (pc != 2 || lat != 4) begin
      failures++;
      $display("FAIL wr_timing got=%0d/%0d exp=2/4", pc, lat);
    end
    checks++;
    if (count !== 16'd1) begin
      failures++;
      $display("FAIL wr_count got=%0d exp=1", count);
    end
    do_read(lat, pc, d);
    checks++;
    if (pc != 2 || lat != 4) begin
      failures++;
      $display("FAIL rd_timing got=%0d/%0d exp=2/4", pc, lat);
    end
    checks++;
    if (d !== 8'hA5 || count !== 16'd0 || rd_empty !== 1'b1) begin
      failures++;
      $display("FAIL rd_data got=%h/%0d/%b exp=a5/0/1",
               d, count, rd_empty);
    end
  endtask

  task automatic test_fill;
    int lat, pc;
    logic [7:0] d;
    for (int k = 1; k <= 8; k++) begin
      do_write(8'(k), lat, pc);
      checks++;
      if (lat != 4) begin
        failures++;
        $display("FAIL fill_wr%0d got=%0d exp=4", k, lat);
      end
    end
    checks++;
    if (wr_full !== 1'b1 || count !== 16'd8) begin
      failures++;
      $display("FAIL full got=%b/%0d exp=1/8", wr_full, count);
    end
    do_write(8'h09, lat, pc);
    checks++;
    if (lat != -1 || pc != 0) begin
      failures++;
      $display("FAIL wr_over got=%0d/%0d exp=-1/0", lat, pc);
    end
    for (int k = 1; k <= 8; k++) begin
      do_read(lat, pc, d);
      checks++;
      if (lat != 4 || d !== 8'(k)) begin
        failures++;
        $display("FAIL drain%0d got=%0d/%h exp=4/%h", k, lat, d, 8'(k));
      end
    end
    do_read(lat, pc, d);
    checks++;
    if (lat != -1 || pc != 0 || rd_empty !== 1'b1) begin
      failures++;
      $display("FAIL rd_under got=%0d/%0d/%b exp=-1/0/1",
               lat, pc, rd_empty);
    end
  endtask

  task automatic test_arbitration;
    int lat, pc, ng, nd;
    logic [7:0] d;
    logic [3:0] seq;
    logic [7:0] rdv[2];
    logic ov, ps, qs, cnt_ok;
    do_write(8'h11, lat, pc);
    do_write(8'h22, lat, pc);
    do_write(8'h33, lat, pc);
    do_write(8'h44, lat, pc);
    do_read(lat, pc, d);
    checks++;
    if (d !== 8'h11 || count !== 16'd3) begin
      failures++;
      $display("FAIL arb_prep got=%h/%0d exp=11/3", d, count);
    end
    seq = 4'b0;
    rdv[0] = 8'h00;
    rdv[1] = 8'h00;
    ng = 0;
    nd = 0;
    ov = 1'b0;
    ps = fifo_push;
    qs = fifo_pop;
    cnt_ok = 1'b1;
    wr_data = 8'h55;
    wr_req = 1'b1;
    rd_req = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (fifo_push && fifo_pop) ov = 1'b1;
      if (fifo_push && !ps && ng < 4) begin
        seq[ng] = 1'b1;
        ng++;
      end
      if (fifo_pop && !qs && ng < 4) begin
        seq[ng] = 1'b0;
        ng++;
      end
      ps = fifo_push;
      qs = fifo_pop;
      if (wr_ack || rd_valid) begin
        nd++;
        if (rd_valid && nd <= 4) rdv[(nd - 1) / 2] = rd_data;
        if ((nd == 2 || nd == 4) && count !== 16'd3) cnt_ok = 1'b0;
        if (nd == 4) begin
          wr_req = 1'b0;
          rd_req = 1'b0;
          break;
        end
      end
    end
    wr_req = 1'b0;
    rd_req = 1'b0;
    checks++;
    if (ng != 4 || seq !== 4'b0101) begin
      failures++;
      $display("FAIL arb_seq got=%0d/%b exp=4/0101", ng, seq);
    end
    checks++;
    if (ov !== 1'b0) begin
      failures++;
      $display("FAIL arb_overlap got=%b exp=0", ov);
    end
    checks++;
    if (cnt_ok !== 1'b1 || nd != 4) begin
      failures++;
      $display("FAIL arb_count got=%b/%0d exp=1/4", cnt_ok, nd);
    end
    checks++;
    if (rdv[0] !== 8'h22 || rdv[1] !== 8'h33) begin
      failures++;
      $display("FAIL arb_data got=%h/%h exp=22/33", rdv[0], rdv[1]);
    end
    checks++;
    if (sync_err !== 1'b0) begin
      failures++;
      $display("FAIL arb_sync got=%b exp=0", sync_err);
    end
  endtask

  task automatic test_reset_midop;
    int lat, pc;
    logic [7:0] d;
    logic acked;
    wr_data = 8'h99;
    wr_req = 1'b1;
    tick();
    checks++;
    if (fifo_push !== 1'b1) begin
      failures++;
      $display("FAIL mid_push got=%b exp=1", fifo_push);
    end
    rst = 1'b1;
    tick();
    wr_req = 1'b0;
    checks++;
    if (fifo_push !== 1'b0 || wr_ack !== 1'b0 ||
        count !== 16'd0 || fifo_clear !== 1'b1) begin
      failures++;
      $display("FAIL mid_rst got=%b/%b/%0d/%b exp=0/0/0/1",
               fifo_push, wr_ack, count, fifo_clear);
    end
    rst = 1'b0;
    acked = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (wr_ack) acked = 1'b1;
    end
    checks++;
    if (acked !== 1'b0) begin
      failures++;
      $display("FAIL mid_noack got=%b exp=0", acked);
    end
    do_write(8'h3C, lat, pc);
    do_read(lat, pc, d);
    checks++;
    if (d !== 8'h3C || lat != 4 || count !== 16'd0) begin
      failures++;
      $display("FAIL mid_recover got=%h/%0d/%0d exp=3c/4/0",
               d, lat, count);
    end
  endtask

  task automatic test_sync;
    checks++;
    if (sync_err !== 1'b0) begin
      failures++;
      $display("FAIL sync_pre got=%b exp=0", sync_err);
    end
    force_pl = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    checks++;
    if (sync_err !== 1'b1) begin
      failures++;
      $display("FAIL sync_set got=%b exp=1", sync_err);
    end
    force_pl = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    checks++;
    if (sync_err !== 1'b1) begin
      failures++;
      $display("FAIL sync_sticky got=%b exp=1", sync_err);
    end
    rst = 1'b1;
    tick();
    checks++;
    if (sync_err !== 1'b0) begin
      failures++;
      $display("FAIL sync_rst got=%b exp=0", sync_err);
    end
    rst = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    checks++;
    if (sync_err !== 1'b0) begin
      failures++;
      $display("FAIL sync_clean got=%b exp=0", sync_err);
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_fill();
    test_arbitration();
    test_reset_midop();
    test_sync();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
